// File: rtl/adaptive_filter_pkg.sv
// Purpose : shared types and saturating arithmetic for the multi-channel adaptive filter.
// Latency : n/a (types and pure functions only).
// Backpressure : n/a.
// Contents: filt_mode_t mode encoding, the wide_t operand type, and sat_max/sat_min/sat_add
//           (range limits for a signed word of a given width, and clamp-with-flag addition).
package adaptive_filter_pkg;

   typedef enum logic [1:0] {
      MODE_DIFF = 2'd0,
      MODE_INT  = 2'd1,
      MODE_BYP  = 2'd2,
      MODE_RSV  = 2'd3
   } filt_mode_t;

   // Widest sample word the arithmetic helpers support. Operands are carried
   // sign-extended to SAT_W_MAX+1 bits, so the sum of two words of any
   // supported width can never wrap before it is clamped.
   localparam int SAT_W_MAX = 32;

   typedef logic signed [SAT_W_MAX:0] wide_t;

   typedef struct packed {
      logic                        sat;
      logic signed [SAT_W_MAX-1:0] val;
   } sat_res_t;

   // Largest value a signed word of width wl can hold: 2^(wl-1)-1.
   function automatic wide_t sat_max(input int wl);
      return (wide_t'(1) <<< (wl - 1)) - wide_t'(1);
   endfunction

   // Smallest value a signed word of width wl can hold: -2^(wl-1).
   function automatic wide_t sat_min(input int wl);
      return -(wide_t'(1) <<< (wl - 1));
   endfunction

   // Adds two sign-extended words and clamps the result to the range of a
   // wl-bit signed word; sat flags that the clamp was applied.
   function automatic sat_res_t sat_add(input wide_t a, input wide_t b, input int wl);
      wide_t    sum;
      wide_t    hi;
      wide_t    lo;
      sat_res_t r;
      sum   = a + b;
      hi    = sat_max(wl);
      lo    = sat_min(wl);
      r.sat = 1'b1;
      if (sum > hi) begin
         r.val = hi[SAT_W_MAX-1:0];
      end else if (sum < lo) begin
         r.val = lo[SAT_W_MAX-1:0];
      end else begin
         r.val = sum[SAT_W_MAX-1:0];
         r.sat = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/adaptive_filter_mc_if.sv
// Purpose : input and output sample streams of the multi-channel adaptive filter.
// Latency : n/a (wires only).
// Backpressure : valid/ready on both streams; a beat moves when tvalid && tready.
// Ports   : s_* sample stream into the filter, m_* filtered stream out (m_tsat = clamped beat).
//           master = sample source / result sink, slave = the filter.
interface adaptive_filter_mc_if #(
   parameter int WORDLENGTH = 14,
   parameter int CH_W       = 2
);
   logic [WORDLENGTH-1:0] s_tdata;
   logic [CH_W-1:0]       s_tuser;
   logic                  s_tvalid;
   logic                  s_tready;
   logic [WORDLENGTH-1:0] m_tdata;
   logic [CH_W-1:0]       m_tuser;
   logic                  m_tsat;
   logic                  m_tvalid;
   logic                  m_tready;

   modport master (
      output s_tdata, s_tuser, s_tvalid, m_tready,
      input  s_tready, m_tdata, m_tuser, m_tsat, m_tvalid
   );

   modport slave (
      input  s_tdata, s_tuser, s_tvalid, m_tready,
      output s_tready, m_tdata, m_tuser, m_tsat, m_tvalid
   );
endinterface

// File: rtl/adaptive_filter_mc_chstate.sv
// Purpose : per-channel history (previous sample and running sum) for the adaptive filter.
// Latency : read is combinational; writes and clears take effect at the next clk edge.
// Backpressure : none; the caller decides when to write.
// Ports   : clk/srst, clr_all (zero every channel), rd_idx -> rd_prev/rd_acc,
//           wr_idx with independent wr_prev_en/wr_acc_en enables.
module adaptive_filter_mc_chstate #(
   parameter int WORDLENGTH   = 14,
   parameter int NUM_CHANNELS = 4,
   parameter int CH_W         = 2
) (
   input  logic                  clk,
   input  logic                  srst,
   input  logic                  clr_all,
   input  logic [CH_W-1:0]       rd_idx,
   output logic [WORDLENGTH-1:0] rd_prev,
   output logic [WORDLENGTH-1:0] rd_acc,
   input  logic [CH_W-1:0]       wr_idx,
   input  logic                  wr_prev_en,
   input  logic [WORDLENGTH-1:0] wr_prev,
   input  logic                  wr_acc_en,
   input  logic [WORDLENGTH-1:0] wr_acc
);
   localparam logic [CH_W:0] NCH = NUM_CHANNELS[CH_W:0];

   logic [WORDLENGTH-1:0] prev_q [NUM_CHANNELS];
   logic [WORDLENGTH-1:0] acc_q  [NUM_CHANNELS];

   // A write on the same edge as clr_all wins: the sample that arrives with a
   // mode change must leave its own history behind. srst beats everything.
   always_ff @(posedge clk) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         if (srst || clr_all) begin
            prev_q[c] <= '0;
            acc_q[c]  <= '0;
         end
         if (!srst && wr_prev_en && (wr_idx == CH_W'(c))) begin
            prev_q[c] <= wr_prev;
         end
         if (!srst && wr_acc_en && (wr_idx == CH_W'(c))) begin
            acc_q[c] <= wr_acc;
         end
      end
   end

   // Out-of-range indices read as zero instead of indexing past the array.
   assign rd_prev = ({1'b0, rd_idx} < NCH) ? prev_q[rd_idx] : '0;
   assign rd_acc  = ({1'b0, rd_idx} < NCH) ? acc_q[rd_idx]  : '0;
endmodule

// File: rtl/adaptive_filter_mc.sv
// Purpose : multi-channel saturating differentiate / integrate / bypass filter.
// Latency : 1 cycle from input accept to m_tvalid; 1 sample/cycle while m_tready=1.
// Backpressure : s_tready = !m_tvalid || m_tready (single output register, no skid).
// Ports   : clk, srst (sync, active-high), ctrl (0 diff, 1 int, 2/3 bypass),
//           bus (s_* in, m_* out), err_ch (1-cycle pulse on out-of-range s_tuser).
module adaptive_filter_mc #(
   parameter int WORDLENGTH        = 14,
   parameter int FRACTIONAL_LENGTH = 6,
   parameter int NUM_CHANNELS      = 4,
   parameter int CH_W              = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
   input  logic                 clk,
   input  logic                 srst,
   input  logic [1:0]           ctrl,
   adaptive_filter_mc_if.slave  bus,
   output logic                 err_ch
);
   import adaptive_filter_pkg::*;

   localparam logic [CH_W:0] NCH = NUM_CHANNELS[CH_W:0];

   // The fractional length only documents the fixed-point format; add and
   // subtract are format-agnostic, so it only has to be sane.
   if (WORDLENGTH < 2 || WORDLENGTH >= SAT_W_MAX || FRACTIONAL_LENGTH < 0 ||
       FRACTIONAL_LENGTH > WORDLENGTH || NUM_CHANNELS < 1) begin : g_param_check
      $error("adaptive_filter_mc: unsupported parameter set");
   end

   filt_mode_t            mode_q;
   filt_mode_t            mode_in;
   logic                  accept;
   logic                  ch_ok;
   logic                  mode_chg;
   logic [WORDLENGTH-1:0] rd_prev;
   logic [WORDLENGTH-1:0] rd_acc;
   wide_t                 x_w;
   wide_t                 prev_w;
   wide_t                 acc_w;
   sat_res_t              res;
   logic [WORDLENGTH-1:0] y;
   logic                  y_sat;
   logic                  wr_prev_en;
   logic                  wr_acc_en;
   logic                  unused_res_hi;

   assign mode_in       = filt_mode_t'(ctrl);
   assign mode_chg      = (mode_in != mode_q);
   assign bus.s_tready  = !bus.m_tvalid || bus.m_tready;
   assign accept        = bus.s_tvalid && bus.s_tready;
   assign ch_ok         = ({1'b0, bus.s_tuser} < NCH);

   adaptive_filter_mc_chstate #(
      .WORDLENGTH   (WORDLENGTH),
      .NUM_CHANNELS (NUM_CHANNELS),
      .CH_W         (CH_W)
   ) u_chstate (
      .clk        (clk),
      .srst       (srst),
      .clr_all    (mode_chg),
      .rd_idx     (bus.s_tuser),
      .rd_prev    (rd_prev),
      .rd_acc     (rd_acc),
      .wr_idx     (bus.s_tuser),
      .wr_prev_en (wr_prev_en),
      .wr_prev    (bus.s_tdata),
      .wr_acc_en  (wr_acc_en),
      .wr_acc     (y)
   );

   // On a mode-change edge the history is being cleared, so the sample that
   // arrives with it must already see zeros rather than the stale registers.
   assign x_w    = wide_t'($signed(bus.s_tdata));
   assign prev_w = mode_chg ? wide_t'(0) : wide_t'($signed(rd_prev));
   assign acc_w  = mode_chg ? wide_t'(0) : wide_t'($signed(rd_acc));

   always_comb begin
      res        = '0;
      y          = bus.s_tdata;
      y_sat      = 1'b0;
      wr_prev_en = 1'b0;
      wr_acc_en  = 1'b0;
      case (mode_in)
         MODE_DIFF: begin
            res        = sat_add(x_w, -prev_w, WORDLENGTH);
            y          = res.val[WORDLENGTH-1:0];
            y_sat      = res.sat;
            wr_prev_en = accept && ch_ok;
         end
         MODE_INT: begin
            res        = sat_add(acc_w, x_w, WORDLENGTH);
            y          = res.val[WORDLENGTH-1:0];
            y_sat      = res.sat;
            wr_acc_en  = accept && ch_ok;
         end
         default: ;
      endcase
   end

   // Clamped results always fit in WORDLENGTH bits; the upper bits are only sign copies.
   assign unused_res_hi = ^res.val[SAT_W_MAX-1:WORDLENGTH];

   always_ff @(posedge clk) begin
      if (srst) begin
         mode_q       <= MODE_DIFF;
         err_ch       <= 1'b0;
         bus.m_tvalid <= 1'b0;
         bus.m_tdata  <= '0;
         bus.m_tuser  <= '0;
         bus.m_tsat   <= 1'b0;
      end else begin
         mode_q <= mode_in;
         err_ch <= accept && !ch_ok;
         if (accept && ch_ok) begin
            bus.m_tvalid <= 1'b1;
            bus.m_tdata  <= y;
            bus.m_tuser  <= bus.s_tuser;
            bus.m_tsat   <= y_sat;
         end else if (bus.m_tready) begin
            bus.m_tvalid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_adaptive_filter_mc.sv
// Purpose : directed bench for adaptive_filter_mc with a per-cycle reference model.
// Latency : the model expects each accepted sample one cycle later.
// Backpressure : exercised by holding m_tready low during a burst.
module tb_adaptive_filter_mc;
   localparam int WL  = 14;
   localparam int NCH = 3;
   localparam int CHW = 2;

   logic       clk = 1'b0;
   logic       srst = 1'b1;
   logic [1:0] ctrl = 2'd0;
   logic       err_ch;

   always #5 clk = ~clk;

   adaptive_filter_mc_if #(.WORDLENGTH(WL), .CH_W(CHW)) bus ();

   adaptive_filter_mc #(
      .WORDLENGTH        (WL),
      .FRACTIONAL_LENGTH (6),
      .NUM_CHANNELS      (NCH)
   ) dut (
      .clk    (clk),
      .srst   (srst),
      .ctrl   (ctrl),
      .bus    (bus.slave),
      .err_ch (err_ch)
   );

   typedef struct {
      int d;
      int u;
      int s;
   } beat_t;

   int    n_vec = 0;
   int    n_miss = 0;
   bit    chk_en = 0;
   bit    e_err = 0;
   int    err_seen = 0;
   int    m_prev [NCH];
   int    m_acc  [NCH];
   int    m_mode = 0;
   beat_t pq [$];
   beat_t cap [$];

   task automatic cmp(input string nm, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int clamp(input int v, output int s);
      s = 1;
      if (v > 8191)  return 8191;
      if (v < -8192) return -8192;
      s = 0;
      return v;
   endfunction

   // Reference model: advances once per rising edge from what the bench drove.
   initial begin : model
      bit    rdy;
      int    x;
      int    c;
      beat_t b;
      beat_t gone;
      forever begin
         @(posedge clk);
         rdy = (pq.size() == 0) || (bus.m_tready === 1'b1);
         if (srst) begin
            pq.delete();
            for (int i = 0; i < NCH; i++) begin m_prev[i] = 0; m_acc[i] = 0; end
            m_mode = 0;
            e_err  = 0;
         end else begin
            if (pq.size() > 0 && bus.m_tready === 1'b1) gone = pq.pop_front();
            if (int'(ctrl) != m_mode) begin
               for (int i = 0; i < NCH; i++) begin m_prev[i] = 0; m_acc[i] = 0; end
               m_mode = int'(ctrl);
            end
            e_err = 0;
            if (bus.s_tvalid === 1'b1 && rdy) begin
               x = int'($signed(bus.s_tdata));
               c = int'(bus.s_tuser);
               if (c >= NCH) begin
                  e_err = 1;
               end else begin
                  b.u = c;
                  b.s = 0;
                  case (m_mode)
                     0: begin b.d = clamp(x - m_prev[c], b.s); m_prev[c] = x; end
                     1: begin b.d = clamp(m_acc[c] + x, b.s); m_acc[c] = b.d; end
                     default: b.d = x;
                  endcase
                  pq.push_back(b);
               end
            end
         end
      end
   end

   // Compare process: every falling edge once reset has been released.
   initial begin : compare
      beat_t h;
      forever begin
         @(negedge clk);
         if (chk_en) begin
            cmp("m_tvalid", int'(bus.m_tvalid), int'(pq.size() > 0));
            cmp("s_tready", int'(bus.s_tready), int'((pq.size() == 0) || bus.m_tready));
            cmp("err_ch", int'(err_ch), int'(e_err));
            if (pq.size() > 0 && bus.m_tvalid === 1'b1) begin
               cmp("m_tdata", int'($signed(bus.m_tdata)), pq[0].d);
               cmp("m_tuser", int'(bus.m_tuser), pq[0].u);
               cmp("m_tsat", int'(bus.m_tsat), pq[0].s);
            end
            if (err_ch === 1'b1) err_seen++;
            if (bus.m_tvalid === 1'b1 && bus.m_tready === 1'b1) begin
               h.d = int'($signed(bus.m_tdata));
               h.u = int'(bus.m_tuser);
               h.s = int'(bus.m_tsat);
               cap.push_back(h);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached, %0d vectors, %0d miscompares", n_vec, n_miss);
      $fatal(1, "watchdog");
   end

   task automatic send(input int ch, input int x);
      bit ok;
      int n;
      bus.s_tvalid = 1'b1;
      bus.s_tdata  = WL'(x);
      bus.s_tuser  = CHW'(ch);
      ok = 0;
      n  = 0;
      while (!ok && n < 50) begin
         @(negedge clk);
         ok = bus.s_tready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!ok) cmp("send timeout", 0, 1);
      bus.s_tvalid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      srst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      srst = 1'b0;
   endtask

   // Literal pin on the k-th beat handed downstream since the last cap.delete().
   task automatic chk_out(input string nm, input int k, input int d, input int u, input int s);
      if (cap.size() <= k) begin
         cmp({nm, " beat count"}, cap.size(), k + 1);
      end else begin
         cmp({nm, " data"}, cap[k].d, d);
         cmp({nm, " user"}, cap[k].u, u);
         cmp({nm, " sat"},  cap[k].s, s);
      end
   endtask

   initial begin : stim
      bus.s_tvalid = 1'b0;
      bus.s_tdata  = '0;
      bus.s_tuser  = '0;
      bus.m_tready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      cmp("rst m_tvalid", int'(bus.m_tvalid), 0);
      cmp("rst m_tdata",  int'(bus.m_tdata), 0);
      cmp("rst m_tuser",  int'(bus.m_tuser), 0);
      cmp("rst m_tsat",   int'(bus.m_tsat), 0);
      cmp("rst err_ch",   int'(err_ch), 0);
      cmp("rst s_tready", int'(bus.s_tready), 1);
      srst   = 1'b0;
      chk_en = 1'b1;

      // Differentiate, single channel.
      cap.delete();
      send(0, 10); send(0, 15); send(0, 12);
      idle(3);
      chk_out("diff0", 0, 10, 0, 0);
      chk_out("diff1", 1, 5, 0, 0);
      chk_out("diff2", 2, -3, 0, 0);

      // Interleaved channels keep independent history.
      do_reset();
      cap.delete();
      send(0, 100); send(1, 7); send(0, 130); send(1, 20);
      idle(3);
      chk_out("ilv0", 0, 100, 0, 0);
      chk_out("ilv1", 1, 7, 1, 0);
      chk_out("ilv2", 2, 30, 0, 0);
      chk_out("ilv3", 3, 13, 1, 0);

      // Integrate with positive and negative saturation.
      ctrl = 2'd1;
      do_reset();
      cap.delete();
      send(2, 8000); send(2, 300); send(2, -100);
      idle(3);
      chk_out("int0", 0, 8000, 2, 0);
      chk_out("int1", 1, 8191, 2, 1);
      chk_out("int2", 2, 8091, 2, 0);
      do_reset();
      cap.delete();
      send(2, -8192); send(2, -8192);
      idle(3);
      chk_out("intn0", 0, -8192, 2, 0);
      chk_out("intn1", 1, -8192, 2, 1);

      // Backpressure in bypass: burst against a stalled sink.
      ctrl = 2'd2;
      do_reset();
      cap.delete();
      bus.m_tready = 1'b0;
      fork
         begin
            send(1, 11); send(1, 22); send(1, 33); send(1, 44);
         end
         begin
            repeat (5) @(negedge clk);
            cmp("bp s_tready", int'(bus.s_tready), 0);
            cmp("bp m_tvalid", int'(bus.m_tvalid), 1);
            cmp("bp m_tdata",  int'($signed(bus.m_tdata)), 11);
            @(posedge clk);
            #1;
            bus.m_tready = 1'b1;
         end
      join
      idle(3);
      chk_out("bp0", 0, 11, 1, 0);
      chk_out("bp1", 1, 22, 1, 0);
      chk_out("bp2", 2, 33, 1, 0);
      chk_out("bp3", 3, 44, 1, 0);
      cmp("bp beat count", cap.size(), 4);

      // Reserved mode passes samples through unclamped and unflagged.
      ctrl = 2'd3;
      cap.delete();
      send(0, -8192); send(0, 8191);
      idle(3);
      chk_out("rsv0", 0, -8192, 0, 0);
      chk_out("rsv1", 1, 8191, 0, 0);

      // Mode switch clears history; the switching sample sees zeros.
      ctrl = 2'd1;
      do_reset();
      cap.delete();
      send(0, 20); send(0, 30);
      ctrl = 2'd0;
      send(0, 9); send(0, 4);
      idle(3);
      chk_out("msw0", 0, 20, 0, 0);
      chk_out("msw1", 1, 50, 0, 0);
      chk_out("msw2", 2, 9, 0, 0);
      chk_out("msw3", 3, -5, 0, 0);

      // Out-of-range channel: consumed, flagged, no output beat.
      cap.delete();
      err_seen = 0;
      send(3, 77); send(1, 5);
      idle(3);
      cmp("bad ch err pulses", err_seen, 1);
      cmp("bad ch beat count", cap.size(), 1);
      chk_out("badch", 0, 5, 1, 0);

      // Reset with a beat waiting in the output register drops it.
      bus.m_tready = 1'b0;
      send(2, 33);
      @(negedge clk);
      cmp("pre-srst m_tvalid", int'(bus.m_tvalid), 1);
      @(posedge clk);
      #1;
      srst = 1'b1;
      @(posedge clk);
      #1;
      cmp("srst m_tvalid", int'(bus.m_tvalid), 0);
      srst = 1'b0;
      bus.m_tready = 1'b1;
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule

// File: doc/adaptive_filter_mc.md
Name: adaptive_filter_mc

Overview:
Multi-channel, parametrised successor of the single-channel adaptive filter. It processes time-interleaved fixed-point samples from NUM_CHANNELS independent channels in one of three runtime-selectable modes: first-difference, accumulate, or bypass. Every channel keeps its own history. Both streams use an AXI-Stream style valid/ready handshake with backpressure, and all arithmetic is saturating. The block sits between the sample source and the downstream DSP chain, replacing the fixed-width, single-channel, no-backpressure filter.

Parameters:
WORDLENGTH, 14, signed sample width in bits (two's complement).
FRACTIONAL_LENGTH, 6, fractional bits. Informational only; add/sub is format-agnostic and no rescaling is done.
NUM_CHANNELS, 4, number of interleaved channels (>=1).
CH_W, max(1,$clog2(NUM_CHANNELS)), channel index width. Derived; do not override.

Ports:
clk  in  1  clock
srst  in  1  synchronous reset, active-high
ctrl  in  2  mode: 0 differentiate, 1 integrate, 2 bypass, 3 reserved (treated as bypass)
s_tdata  in  WORDLENGTH  input sample, signed
s_tuser  in  CH_W  channel index of s_tdata
s_tvalid  in  1  input valid
s_tready  out  1  input ready
m_tdata  out  WORDLENGTH  output sample, signed
m_tuser  out  CH_W  channel index of m_tdata (echo of s_tuser)
m_tsat  out  1  this output beat was saturated
m_tvalid  out  1  output valid
m_tready  in  1  output ready
err_ch  out  1  one-cycle pulse: a sample arrived with an out-of-range channel index

Behaviour:
- Reset values: m_tvalid=0, m_tdata=0, m_tuser=0, m_tsat=0, err_ch=0, mode_q=0, all per-channel prev_x and acc = 0.
- srst mid-operation: the in-flight output beat is discarded and all history is cleared on the same edge.
- s_tready = !m_tvalid || m_tready (combinational; single output register, no skid buffer).
- Accept: s_tvalid && s_tready at a rising edge.
- Latency: exactly 1 cycle. A sample accepted at edge k appears with m_tvalid=1 after edge k. Full throughput is 1 sample/cycle while m_tready=1.
- Hold while stalled: when m_tvalid && !m_tready, m_tdata, m_tuser and m_tsat hold stable. m_tvalid deasserts only after a handshake with no new accept.
- Differentiate, channel c: y = sat(x - prev_x[c]), then prev_x[c] <= x.
- Integrate, channel c: y = sat(acc[c] + x), then acc[c] <= y (the saturated value).
- Bypass: y = x, m_tsat=0, history untouched.
- Channel state: prev_x[c] and acc[c] update only on accept for that channel; other channels are unaffected. The first diff sample on a channel after reset or clear gives y = x.
- Saturation: compute at WORDLENGTH+1 bits, clamp to [-2^(WORDLENGTH-1), 2^(WORDLENGTH-1)-1], and set m_tsat=1 for that beat when clamped.
- Mode change: ctrl is registered into mode_q every cycle.
  - When ctrl != mode_q, all channels' prev_x and acc clear on that edge.
  - A sample accepted on that same edge is processed in the new mode against zeroed history.
  - An output already in m_tdata is unaffected.
- Bad channel (s_tuser >= NUM_CHANNELS):
  - The sample is consumed (s_tready behaves normally).
  - No output beat is produced and no state changes.
  - err_ch pulses high for 1 cycle after the accept edge.
- Ports are unsigned bit vectors; the datapath interprets them as signed.

Decomposition:
- Package adaptive_filter_pkg holds:
  - typedef enum logic [1:0] filt_mode_t {MODE_DIFF, MODE_INT, MODE_BYP, MODE_RSV};
  - a sat_add function (WORDLENGTH+1 bits in, clamped value plus sat flag out);
  - the min/max constants derived from WORDLENGTH.
- Sub-module adaptive_filter_mc_chstate: per-channel register file (prev_x, acc) with one read port indexed by s_tuser, one write port, and a synchronous clear-all input. It maps to registers at NUM_CHANNELS<=16.
- The top level holds the handshake, mode tracking, arithmetic and output register.

Test Plan:
- Reset, diff mode, channel 0 stream 10, 15, 12, m_tready=1 -> m_tdata -5... no: m_tdata = 10, 5, -3, each 1 cycle after its accept; m_tsat=0.
- Interleaved diff, channel sequence 0,1,0,1 with data 100, 7, 130, 20 -> outputs 100, 7, 30, 13 with m_tuser 0,1,0,1 (histories are independent).
- Integrate channel 2 with 8000, then 300, then -100 -> outputs 8000, 8191 (m_tsat=1), 8091. Then -8192 twice from a fresh reset -> -8192, then -8192 (m_tsat=1).
- Backpressure: hold m_tready=0 for 5 cycles with s_tvalid=1 -> s_tready=0 after the first accept and m_tdata stable. Release -> no sample lost or duplicated; output order is preserved.
- Mode switch: integrate to acc[0]=50, switch ctrl to 0 while feeding channel 0 sample 9 on the same cycle -> output 9; the next sample 4 gives -5.
- Bad channel with NUM_CHANNELS=3, s_tuser=3 -> err_ch pulses once, no m_tvalid, and the next valid channel output is correct. srst asserted with m_tvalid=1 -> m_tvalid=0 the next cycle.
